imm_gen_stage: RTL and testbench

Registered, parametrised immediate generator for the pipelined core's decode stage. It extracts and sign- or zero-extends the immediate to XLEN, adds CSR zimm and shift-amount formats, and precomputes the branch/jump target (pc + imm). A valid/ready handshake and a 2-entry skid buffer let the stage stall without a combinational ready path. A flush input squashes in-flight entries on redirect.

---
 rtl/imm_gen_stage.sv | 119 +++++++++++
 tb/tb_imm_gen_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator with a registered output stage and a
// 2-entry skid buffer; also precomputes the pc-relative target.
module imm_gen_stage #(
    parameter int XLEN        = 32,
    parameter bit ENABLE_ZIMM = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     inst_i,
    input  logic [2:0]      imm_src_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_ext_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            imm_err_o
);

    // Handshake: an entry moves across an interface on a rising edge where
    // valid and ready are both high. valid_o and the payload stay stable
    // while valid_o=1 and ready_i=0. ready_o comes straight from a flop
    // (!skid_valid), so it has no combinational dependence on ready_i.

    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] tgt_c;
    logic            err_c;

    // Signed formats start from all-ones/zeros of the sign and overwrite the
    // low bits; this keeps every case width-independent of XLEN.
    always_comb begin
        imm_c = {XLEN{inst_i[31]}};
        err_c = 1'b0;
        case (imm_src_i)
            3'b000: imm_c[11:0] = inst_i[31:20];
            3'b001: imm_c[11:0] = {inst_i[31:25], inst_i[11:7]};
            3'b010: imm_c[12:0] = {inst_i[31], inst_i[7], inst_i[30:25],
                                   inst_i[11:8], 1'b0};
            3'b011: imm_c[31:0] = {inst_i[31:12], 12'b0};
            3'b100: imm_c[20:0] = {inst_i[31], inst_i[19:12], inst_i[20],
                                   inst_i[30:21], 1'b0};
            3'b101: begin
                imm_c = '0;
                if (ENABLE_ZIMM) imm_c[4:0] = inst_i[19:15];
                else             err_c      = 1'b1;
            end
            3'b110: begin
                imm_c = '0;
                if (!ENABLE_ZIMM)    err_c      = 1'b1;
                else if (XLEN == 64) imm_c[5:0] = inst_i[25:20];
                else                 imm_c[4:0] = inst_i[24:20];
            end
            default: begin
                imm_c = '0;
                err_c = 1'b1;
            end
        endcase
        tgt_c = pc_i + imm_c;
    end

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^inst_i[6:0];

    logic            main_valid, skid_valid;
    logic [XLEN-1:0] main_imm, main_tgt, skid_imm, skid_tgt;
    logic            main_err, skid_err;
    logic            accept, xfer;

    assign ready_o = !skid_valid;
    assign accept  = valid_i && ready_o && !flush_i && !rst_i;
    assign xfer    = main_valid && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tgt   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tgt   <= '0;
            skid_err   <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || xfer) begin
            // Skid holds the older entry; while it is full ready_o=0, so
            // no new entry can race it into main.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tgt   <= skid_tgt;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= imm_c;
                main_tgt   <= tgt_c;
                main_err   <= err_c;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= imm_c;
            skid_tgt   <= tgt_c;
            skid_err   <= err_c;
        end
    end

    assign valid_o     = main_valid;
    assign imm_ext_o   = main_imm;
    assign pc_target_o = main_tgt;
    assign imm_err_o   = main_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three instances (XLEN=32, XLEN=32 without
// zimm, XLEN=64) share one stimulus stream; each vector names the checked one.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic [31:0] inst_i;
    logic [2:0]  imm_src_i;
    logic [63:0] pc_i;
    logic [31:0] pc32;

    logic        v0, r0, e0, v1, r1, e1, v2, r2, e2;
    logic [31:0] imm0, tgt0, imm1, tgt1;
    logic [63:0] imm2, tgt2;

    int checks = 0;
    int errors = 0;

    assign pc32 = pc_i[31:0];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .ENABLE_ZIMM(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(r0), .inst_i(inst_i), .imm_src_i(imm_src_i), .pc_i(pc32),
        .valid_o(v0), .ready_i(ready_i), .imm_ext_o(imm0),
        .pc_target_o(tgt0), .imm_err_o(e0));

    imm_gen_stage #(.XLEN(32), .ENABLE_ZIMM(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(r1), .inst_i(inst_i), .imm_src_i(imm_src_i), .pc_i(pc32),
        .valid_o(v1), .ready_i(ready_i), .imm_ext_o(imm1),
        .pc_target_o(tgt1), .imm_err_o(e1));

    imm_gen_stage #(.XLEN(64), .ENABLE_ZIMM(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(r2), .inst_i(inst_i), .imm_src_i(imm_src_i), .pc_i(pc_i),
        .valid_o(v2), .ready_i(ready_i), .imm_ext_o(imm2),
        .pc_target_o(tgt2), .imm_err_o(e2));

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] inst;
        logic [2:0]  src;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_out(input int dut, output logic v, output logic r,
                           output logic [63:0] imm, output logic [63:0] tgt,
                           output logic e);
        case (dut)
            0:       begin v = v0; r = r0; imm = {32'b0, imm0}; tgt = {32'b0, tgt0}; e = e0; end
            1:       begin v = v1; r = r1; imm = {32'b0, imm1}; tgt = {32'b0, tgt1}; e = e1; end
            default: begin v = v2; r = r2; imm = imm2; tgt = tgt2; e = e2; end
        endcase
    endtask

    task automatic check_idle(input string name, input int dut);
        logic v, r, e;
        logic [63:0] imm, tgt;
        get_out(dut, v, r, imm, tgt, e);
        check({name, ".valid"}, {63'b0, v}, 64'd0);
        check({name, ".ready"}, {63'b0, r}, 64'd1);
        check({name, ".imm"}, imm, 64'd0);
        check({name, ".tgt"}, tgt, 64'd0);
        check({name, ".err"}, {63'b0, e}, 64'd0);
    endtask

    // Drive one entry at the negedge; it is captured at the following edge.
    task automatic drive(input logic [31:0] inst, input logic [2:0] src,
                         input logic [63:0] pc);
        valid_i   = 1'b1;
        inst_i    = inst;
        imm_src_i = src;
        pc_i      = pc;
    endtask

    initial begin
        vec_t vv;
        logic v, r, e;
        logic [63:0] imm, tgt;
        logic acc;

        vecs.push_back('{"i_neg",    0, 32'hFFF00093, 3'b000, 64'h100,  64'hFFFFFFFF,         64'hFF,                  1'b0});
        vecs.push_back('{"b_neg",    0, 32'hFE000EE3, 3'b010, 64'h200,  64'hFFFFFFFC,         64'h1FC,                 1'b0});
        vecs.push_back('{"j_pos",    0, 32'h0080006F, 3'b100, 64'h200,  64'h8,                64'h208,                 1'b0});
        vecs.push_back('{"z",        0, 32'h000FD073, 3'b101, 64'h40,   64'h1F,               64'h5F,                  1'b0});
        vecs.push_back('{"z_off",    1, 32'h000FD073, 3'b101, 64'h40,   64'h0,                64'h40,                  1'b1});
        vecs.push_back('{"sh_off",   1, 32'h03F01013, 3'b110, 64'h40,   64'h0,                64'h40,                  1'b1});
        vecs.push_back('{"rsvd",     0, 32'h12345678, 3'b111, 64'h80,   64'h0,                64'h80,                  1'b1});
        vecs.push_back('{"s_neg",    0, 32'hFE112E23, 3'b001, 64'h1000, 64'hFFFFFFFC,         64'hFFC,                 1'b0});
        vecs.push_back('{"u32",      0, 32'h800002B7, 3'b011, 64'h10,   64'h80000000,         64'h80000010,            1'b0});
        vecs.push_back('{"sh32",     0, 32'h03F01013, 3'b110, 64'h0,    64'h1F,               64'h1F,                  1'b0});
        vecs.push_back('{"u64",      2, 32'h800002B7, 3'b011, 64'h10,   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000010,    1'b0});
        vecs.push_back('{"sh64",     2, 32'h03F01013, 3'b110, 64'h0,    64'h3F,               64'h3F,                  1'b0});
        vecs.push_back('{"i64_pos",  2, 32'h7FF00093, 3'b000, 64'h100,  64'h7FF,              64'h8FF,                 1'b0});
        vecs.push_back('{"b64_neg",  2, 32'hFE000EE3, 3'b010, 64'h200,  64'hFFFFFFFFFFFFFFFC, 64'h1FC,                 1'b0});
        vecs.push_back('{"rsvd64",   2, 32'hFFFFFFFF, 3'b111, 64'h300,  64'h0,                64'h300,                 1'b1});

        // Clock/reset
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        inst_i = '0; imm_src_i = '0; pc_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check_idle("reset_u0", 0);
        check_idle("reset_u1", 1);
        check_idle("reset_u2", 2);

        // Table-driven single-entry vectors, ready_i held high.
        foreach (vecs[k]) begin
            vv = vecs[k];
            @(negedge clk);
            drive(vv.inst, vv.src, vv.pc);
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            get_out(vv.dut, v, r, imm, tgt, e);
            check({vv.name, ".valid"}, {63'b0, v}, 64'd1);
            check({vv.name, ".imm"}, imm, vv.imm);
            check({vv.name, ".tgt"}, tgt, vv.tgt);
            check({vv.name, ".err"}, {63'b0, e}, {63'b0, vv.err});
        end
        @(negedge clk);
        @(negedge clk);
        check("drain.valid", {63'b0, v0}, 64'd0);

        // Back-pressure: A to main, B to skid, C refused until room appears.
        ready_i = 1'b0;
        drive(32'h00100093, 3'b000, 64'h0); exp_q.push_back(64'h1);
        @(negedge clk);
        drive(32'h00200093, 3'b000, 64'h0); exp_q.push_back(64'h2);
        @(negedge clk);
        check("stall.ready", {63'b0, r0}, 64'd0);
        check("stall.valid", {63'b0, v0}, 64'd1);
        check("stall.hold_a", {32'b0, imm0}, 64'h1);
        drive(32'h00300093, 3'b000, 64'h0); exp_q.push_back(64'h3);
        @(posedge clk);
        #1;
        check("stall.hold_a2", {32'b0, imm0}, 64'h1);
        check("stall.ready2", {63'b0, r0}, 64'd0);
        @(negedge clk);
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (v0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL order: extra entry 0x%0h with nothing expected", imm0);
                end else begin
                    check("order.imm", {32'b0, imm0}, exp_q.pop_front());
                end
            end
            acc = valid_i && r0;
            @(posedge clk);
            #1;
            if (acc) valid_i = 1'b0;
            @(negedge clk);
        end
        check("order.left", 64'(exp_q.size()), 64'd0);
        check("order.idle", {63'b0, v0}, 64'd0);
        check("order.ready", {63'b0, r0}, 64'd1);

        // Flush with A in main, B in skid, D offered in the flush cycle.
        ready_i = 1'b0;
        drive(32'h00400093, 3'b000, 64'h0);
        @(negedge clk);
        drive(32'h00500093, 3'b000, 64'h0);
        @(negedge clk);
        check("flush.pre_ready", {63'b0, r0}, 64'd0);
        flush_i = 1'b1;
        drive(32'h00600093, 3'b000, 64'h0);
        @(posedge clk);
        #1;
        check("flush.valid", {63'b0, v0}, 64'd0);
        check("flush.ready", {63'b0, r0}, 64'd1);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk);
            #1;
            check("flush.no_d", {63'b0, v0}, 64'd0);
        end

        // Reset during a stall on the 64-bit instance.
        @(negedge clk);
        ready_i = 1'b0;
        drive(32'h800002B7, 3'b011, 64'h10);
        @(negedge clk);
        drive(32'h03F01013, 3'b110, 64'h0);
        @(negedge clk);
        valid_i = 1'b0;
        check("rst.pre_valid", {63'b0, v2}, 64'd1);
        check("rst.pre_imm", imm2, 64'hFFFFFFFF80000000);
        check("rst.pre_ready", {63'b0, r2}, 64'd0);
        rst_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rst_stall_u2", 2);
        @(negedge clk);
        rst_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst.after", {63'b0, v2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
